// File: rtl/ota_bitstream_decimator_if.sv
// rtl/ota_bitstream_decimator_if.sv - density code handshake from decimator to digital core
interface ota_bitstream_decimator_if #(
  parameter int DATA_W = 9
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/ota_bitstream_decimator.sv
// rtl/ota_bitstream_decimator.sv - synchronises the comparator bitstream and emits a ones-count per window
module ota_bitstream_decimator #(
  parameter int WIN_LOG2 = 8,
  parameter int DIV      = 4,
  parameter int DATA_W   = WIN_LOG2 + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic bit_in,
  input  logic clr_ovr,
  output logic overrun,
  output logic busy,
  ota_bitstream_decimator_if.master out_if
);
  localparam int                  PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [WIN_LOG2-1:0] WIN_LAST = '1;

  typedef enum logic {IDLE = 1'b0, ACQ = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                s1_q, s2_q;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [WIN_LOG2-1:0] win_q, win_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                overrun_q, overrun_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   result;
  logic                strobe, res_vld, drop;

  always_comb begin
    state_d = state_q;
    pre_d   = '0;
    win_d   = '0;
    acc_d   = '0;
    strobe  = 1'b0;
    res_vld = 1'b0;
    result  = acc_q + DATA_W'(s2_q);
    case (state_q)
      IDLE: if (en) state_d = ACQ;
      ACQ: begin
        // Dropping en abandons the partial window, even on its final strobe.
        if (!en) begin
          state_d = IDLE;
        end else begin
          strobe = (pre_q == PRE_LAST);
          pre_d  = strobe ? '0 : pre_q + 1'b1;
          win_d  = win_q;
          acc_d  = acc_q;
          if (strobe) begin
            if (win_q == WIN_LAST) begin
              res_vld = 1'b1;
              win_d   = '0;
              acc_d   = '0;
            end else begin
              win_d = win_q + 1'b1;
              acc_d = result;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == ACQ);

    drop        = res_vld & out_valid_q & ~out_if.out_ready;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (res_vld && (!out_valid_q || out_if.out_ready)) begin
      out_data_d  = result;
      out_valid_d = 1'b1;
    end else if (!res_vld && out_valid_q && out_if.out_ready) begin
      out_valid_d = 1'b0;
    end
    overrun_d = (overrun_q & ~clr_ovr) | drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      pre_q       <= '0;
      win_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= bit_in;
      s2_q        <= s1_q;
      pre_q       <= pre_d;
      win_q       <= win_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;
  assign overrun          = overrun_q;
  assign busy             = busy_q;
endmodule

// File: tb/tb_ota_bitstream_decimator.sv
// tb/tb_ota_bitstream_decimator.sv - randomized bench for two decimator configurations against a window model
module tb_ota_bitstream_decimator;
  localparam int WL = 4;
  localparam int N  = 1 << WL;
  localparam int DW = WL + 1;

  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, bit_in = 1'b0, clr_ovr = 1'b0, rdy = 1'b0;
  logic ovr_a, busy_a, ovr_b, busy_b;

  ota_bitstream_decimator_if #(.DATA_W(DW)) if_a ();
  ota_bitstream_decimator_if #(.DATA_W(DW)) if_b ();
  assign if_a.out_ready = rdy;
  assign if_b.out_ready = rdy;

  ota_bitstream_decimator #(.WIN_LOG2(WL), .DIV(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .bit_in(bit_in), .clr_ovr(clr_ovr),
    .overrun(ovr_a), .busy(busy_a), .out_if(if_a.master));
  ota_bitstream_decimator #(.WIN_LOG2(WL), .DIV(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .bit_in(bit_in), .clr_ovr(clr_ovr),
    .overrun(ovr_b), .busy(busy_b), .out_if(if_b.master));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: samples seen by the window are the pin values from two edges earlier.
  localparam int DIVS[2] = '{1, 2};
  bit  hist[$];
  bit  m_acq[2], m_v[2], m_o[2];
  int  m_t[2], m_cnt[2], m_sum[2], m_d[2];

  initial begin
    hist = '{1'b0, 1'b0};
    for (int i = 0; i < 2; i++) begin
      m_acq[i] = 0; m_v[i] = 0; m_o[i] = 0;
      m_t[i] = 0; m_cnt[i] = 0; m_sum[i] = 0; m_d[i] = 0;
    end
  end

  always @(posedge clk) begin
    bit s2, prod, drop;
    int res;
    if (rst) begin
      hist = '{1'b0, 1'b0};
      for (int i = 0; i < 2; i++) begin
        m_acq[i] = 0; m_v[i] = 0; m_o[i] = 0;
        m_t[i] = 0; m_cnt[i] = 0; m_sum[i] = 0; m_d[i] = 0;
      end
    end else begin
      s2 = hist[0];
      void'(hist.pop_front());
      hist.push_back(bit_in);
      for (int i = 0; i < 2; i++) begin
        prod = 0;
        res  = 0;
        if (!m_acq[i]) begin
          if (en) begin m_acq[i] = 1; m_t[i] = 0; m_cnt[i] = 0; m_sum[i] = 0; end
        end else if (!en) begin
          m_acq[i] = 0; m_cnt[i] = 0; m_sum[i] = 0;
        end else begin
          m_t[i]++;
          if (m_t[i] % DIVS[i] == 0) begin
            m_cnt[i]++;
            m_sum[i] += int'(s2);
            if (m_cnt[i] == N) begin
              prod = 1; res = m_sum[i]; m_cnt[i] = 0; m_sum[i] = 0;
            end
          end
        end
        drop = prod && m_v[i] && !rdy;
        if (prod && (!m_v[i] || rdy)) begin
          m_d[i] = res; m_v[i] = 1;
        end else if (!prod && m_v[i] && rdy) begin
          m_v[i] = 0;
        end
        m_o[i] = (m_o[i] && !clr_ovr) || drop;
      end
    end
  end

  task automatic cycle();
    @(negedge clk);
    check_val("a_valid",   int'(if_a.out_valid), int'(m_v[0]));
    check_val("a_data",    int'(if_a.out_data),  m_d[0]);
    check_val("a_overrun", int'(ovr_a),          int'(m_o[0]));
    check_val("a_busy",    int'(busy_a),         int'(m_acq[0]));
    check_val("b_valid",   int'(if_b.out_valid), int'(m_v[1]));
    check_val("b_data",    int'(if_b.out_data),  m_d[1]);
    check_val("b_overrun", int'(ovr_b),          int'(m_o[1]));
    check_val("b_busy",    int'(busy_b),         int'(m_acq[1]));
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_reset(input logic b);
    rst = 1'b1; en = 1'b0; clr_ovr = 1'b0; bit_in = b;
    cycles(2);
    rst = 1'b0;
    cycles(3);
  endtask

  initial begin
    rdy = 1'b1;
    do_reset(1'b1);
    check_val("rst_valid", int'(if_a.out_valid), 0);
    check_val("rst_data",  int'(if_a.out_data),  0);
    check_val("rst_ovr",   int'(ovr_a),          0);
    check_val("rst_busy",  int'(busy_b),         0);

    // Constant ones: first code 16 edges after entry (DIV=1), 32 edges (DIV=2).
    en = 1'b1;
    cycles(16);
    check_val("t1_not_yet", int'(if_a.out_valid), 0);
    cycle();
    check_val("t1_valid", int'(if_a.out_valid), 1);
    check_val("t1_data",  int'(if_a.out_data),  N);
    cycles(16);
    check_val("t1_b_valid", int'(if_b.out_valid), 1);
    check_val("t1_b_data",  int'(if_b.out_data),  N);

    // Reset while a code is pending.
    rdy = 1'b0;
    cycles(5);
    rst = 1'b1;
    cycle();
    check_val("t6_valid", int'(if_a.out_valid), 0);
    check_val("t6_data",  int'(if_a.out_data),  0);
    check_val("t6_ovr",   int'(ovr_a),          0);
    check_val("t6_busy",  int'(busy_a),         0);
    rdy = 1'b1;
    do_reset(1'b1);

    // Alternating samples at the DIV=2 strobe rate.
    en = 1'b1;
    for (int k = 0; k < 33; k++) begin
      bit_in = ((k / 2) % 2) != 0;
      cycle();
    end
    check_val("t2_b_valid", int'(if_b.out_valid), 1);
    check_val("t2_b_data",  int'(if_b.out_data),  N / 2);
    for (int k = 33; k < 200; k++) begin
      bit_in = ((k / 2) % 2) != 0;
      cycle();
    end

    // Constant zero with the consumer stalled, then clear the overrun flag.
    do_reset(1'b0);
    rdy = 1'b0;
    en  = 1'b1;
    cycles(40);
    check_val("t3_valid", int'(if_a.out_valid), 1);
    check_val("t3_data",  int'(if_a.out_data),  0);
    check_val("t3_ovr",   int'(ovr_a),          1);
    clr_ovr = 1'b1;
    cycle();
    clr_ovr = 1'b0;
    check_val("t3_clr", int'(ovr_a), 0);

    // Abandoned partial window then a full fresh window.
    rdy = 1'b1;
    do_reset(1'b1);
    en = 1'b1;
    cycles(11);
    en = 1'b0;
    cycles(4);
    check_val("t4_none", int'(if_a.out_valid), 0);
    en = 1'b1;
    cycles(16);
    check_val("t4_not_yet", int'(if_a.out_valid), 0);
    cycle();
    check_val("t4_valid", int'(if_a.out_valid), 1);
    check_val("t4_data",  int'(if_a.out_data),  N);

    // Randomized traffic: random pin, ready, en drops, clears and resets.
    for (int k = 0; k < 4000; k++) begin
      bit_in  = ($urandom_range(0, 99) < 70);
      rdy     = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) en = ~en;
      else if (!en && $urandom_range(0, 7) == 0) en = 1'b1;
      clr_ovr = ($urandom_range(0, 63) == 0);
      rst     = ($urandom_range(0, 999) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
